fwd_ctrl: RTL and testbench
===========================

Name: fwd_ctrl

Overview:
- Forwarding and hazard controller that drives the 2-bit selects of the 64-bit 4:1 operand-bypass muxes at the EX-stage inputs.
- Tracks the destination register of every in-flight instruction in a private EX/MEM/WB shadow pipeline.
- Compares each decoding instruction's sources against that shadow pipeline and registers the resulting selects into EX.
- Detects load-use hazards, asserts stall, and injects a bubble.

Parameters:
- REG_W, 5, register-index width.
- ZERO_REG, 31, index of XZR; never forwarded and never a hazard source.
- RF_WRITE_THROUGH, 1, 1 = register file bypasses same-cycle writes, so sel 11 is never generated; 0 = enable WB-hold forwarding.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rn  in  REG_W  source A index
- id_rm  in  REG_W  source B index
- id_use_rn  in  1  instruction reads rn
- id_use_rm  in  1  instruction reads rm
- id_rd  in  REG_W  destination index
- id_regwrite  in  1  instruction writes rd
- id_memread  in  1  instruction is a load
- flush  in  1  kill the ID instruction (branch taken)
- stall  out  1  combinational; hold PC and IF/ID register
- fwd_a_sel  out  2  registered select for operand-A mux
- fwd_b_sel  out  2  registered select for operand-B mux
- ex_valid  out  1  EX slot holds a real instruction

Behaviour:
- Reset (async, reset_n=0): all shadow valid bits, regwrite and memread flags 0; fwd_a_sel=fwd_b_sel=00; ex_valid=0. stall=0 because no valid EX entry exists.
- Select encoding, from package: 00 REGFILE, 01 EXMEM (ALU result one stage ahead), 10 MEMWB, 11 WBHOLD (value retired last cycle).
- Shadow stages EX, MEM, WB each hold {valid, rd, regwrite, memread}. Every edge: WB<=MEM and MEM<=EX, unconditionally.
- EX load rule:
  - EX<=ID when id_valid & !stall & !flush.
  - Otherwise EX<=bubble (valid=0).
  - A stalled ID instruction is held by the upstream IF/ID register, not by this block.
- Match rule for a source s against stage X: X.valid & X.regwrite & X.rd==s & s!=ZERO_REG & use_s.
- Selects are computed in ID and registered at the edge the instruction enters EX. Priority, youngest first:
  - match current EX → 01.
  - else match current MEM → 10.
  - else match current WB and RF_WRITE_THROUGH==0 → 11.
  - else 00.
- When EX loads a bubble, both selects register 00.
- Load-use: stall = id_valid & !flush & EX.valid & EX.memread & (match on rn or rm against EX). Next cycle the load is in MEM, and the re-evaluated ID instruction then selects 10. Latency is exactly one bubble per load-use.
- Two consecutive loads feeding one consumer produce one stall only. The newest load is the only one checked.
- Flush has priority over stall. Stall is masked to 0, the ID instruction is dropped, and EX gets a bubble. Older stages keep advancing.
- Same register in rn and rm: both selects get identical codes.
- Reset asserted mid-stream clears all stages immediately with no partial forwarding. The first instruction after reset release sees 00/00.

Decomposition:
- Package fwd_pkg holds: fwd_sel_t (2-bit enum REGFILE/EXMEM/MEMWB/WBHOLD), stage_info_t struct {valid, rd, regwrite, memread}, and the ZERO_REG constant.
- One natural sub-module, fwd_match: combinational, takes a source index plus the three stage_info_t values and returns the fwd_sel_t and an ex_load_hit bit. It is instantiated twice, once for rn and once for rm.

Test Plan:
- ADD X1 (rd=1, regwrite) then SUB using rn=1 → after the SUB enters EX: fwd_a_sel=01, fwd_b_sel=00, stall never asserted.
- ADD X2, NOP, then ORR rm=2 → fwd_b_sel=10. Repeat with two NOPs and RF_WRITE_THROUGH=0 → 11; with RF_WRITE_THROUGH=1 → 00.
- LDUR X3, then ADD rn=3, rm=3:
  - stall=1 for exactly one cycle, with ex_valid=0 the following cycle.
  - Then both selects are 10.
- Write to X31 (rd=31, regwrite) then a read of rn=31 → selects 00, no stall.
- LDUR X4, then ADD rn=4 with flush=1 in the same cycle → stall=0; EX gets a bubble, ex_valid=0, selects 00.
- Pulse reset_n low between the ADD X5 writer and the dependent reader → all outputs 0 asynchronously; the post-reset reader of X5 sees 00.

Source files
------------

// File: rtl/fwd_pkg.sv
// ============================================================================
// Module      : fwd_pkg
// Description : Shared types and constants for the operand forwarding logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    localparam int C_REG_W    = 5;
    localparam int C_ZERO_REG = 31;

    // Select codes driven onto the EX-stage 4:1 bypass muxes
    typedef enum logic [1:0] {
        REGFILE = 2'b00,
        EXMEM   = 2'b01,
        MEMWB   = 2'b10,
        WBHOLD  = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic               valid;
        logic [C_REG_W-1:0] rd;
        logic               regwrite;
        logic               memread;
    } stage_info_t;

    localparam stage_info_t C_BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, memread: 1'b0};

endpackage : fwd_pkg

`default_nettype wire

// File: rtl/fwd_match.sv
// ============================================================================
// Module      : fwd_match
// Description : Compares one source index against the EX/MEM/WB shadow stages
//               and returns the youngest-first bypass select.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_match
    import fwd_pkg::*;
#(
    parameter int ZERO_REG         = C_ZERO_REG,
    parameter int RF_WRITE_THROUGH = 1
) (
    input  logic [C_REG_W-1:0] src,
    input  logic               use_src,
    input  stage_info_t        ex_stage,
    input  stage_info_t        mem_stage,
    input  stage_info_t        wb_stage,
    output fwd_sel_t           sel,
    output logic               ex_load_hit
);

    localparam logic [C_REG_W-1:0] c_zero = C_REG_W'(ZERO_REG);

    logic w_src_ok;
    logic w_hit_ex;
    logic w_hit_mem;
    logic w_hit_wb;
    logic w_wbhold_en;
    logic w_unused_memread;

    // A register file that writes through makes the WB-hold path redundant
    generate
        if (RF_WRITE_THROUGH == 0) begin : g_wbhold_on
            assign w_wbhold_en = 1'b1;
        end else begin : g_wbhold_off
            assign w_wbhold_en = 1'b0;
        end
    endgenerate

    assign w_src_ok  = use_src & (src != c_zero);
    assign w_hit_ex  = w_src_ok & ex_stage.valid  & ex_stage.regwrite  & (ex_stage.rd  == src);
    assign w_hit_mem = w_src_ok & mem_stage.valid & mem_stage.regwrite & (mem_stage.rd == src);
    assign w_hit_wb  = w_src_ok & wb_stage.valid  & wb_stage.regwrite  & (wb_stage.rd  == src);

    assign w_unused_memread = mem_stage.memread ^ wb_stage.memread;

    always_comb begin
        sel = REGFILE;
        if (w_hit_ex) begin
            sel = EXMEM;
        end else if (w_hit_mem) begin
            sel = MEMWB;
        end else if (w_hit_wb && w_wbhold_en) begin
            sel = WBHOLD;
        end
    end

    assign ex_load_hit = w_hit_ex & ex_stage.memread;

endmodule : fwd_match

`default_nettype wire

// File: rtl/fwd_ctrl.sv
// ============================================================================
// Module      : fwd_ctrl
// Description : Forwarding and load-use hazard controller; tracks in-flight
//               destinations and registers bypass selects into EX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_W            = C_REG_W,
    parameter int ZERO_REG         = C_ZERO_REG,
    parameter int RF_WRITE_THROUGH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             ex_valid
);

    stage_info_t r_ex;
    stage_info_t r_mem;
    stage_info_t r_wb;
    fwd_sel_t    r_fwd_a;
    fwd_sel_t    r_fwd_b;

    stage_info_t w_id_info;
    fwd_sel_t    w_sel_a;
    fwd_sel_t    w_sel_b;
    logic        w_load_hit_a;
    logic        w_load_hit_b;
    logic        w_ex_load;

    assign w_id_info = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

    fwd_match #(
        .ZERO_REG         (ZERO_REG),
        .RF_WRITE_THROUGH (RF_WRITE_THROUGH)
    ) u_match_rn (
        .src         (id_rn),
        .use_src     (id_use_rn),
        .ex_stage    (r_ex),
        .mem_stage   (r_mem),
        .wb_stage    (r_wb),
        .sel         (w_sel_a),
        .ex_load_hit (w_load_hit_a)
    );

    fwd_match #(
        .ZERO_REG         (ZERO_REG),
        .RF_WRITE_THROUGH (RF_WRITE_THROUGH)
    ) u_match_rm (
        .src         (id_rm),
        .use_src     (id_use_rm),
        .ex_stage    (r_ex),
        .mem_stage   (r_mem),
        .wb_stage    (r_wb),
        .sel         (w_sel_b),
        .ex_load_hit (w_load_hit_b)
    );

    // Only the load currently in EX can stall; older loads are already bypassable
    assign stall     = id_valid & ~flush & (w_load_hit_a | w_load_hit_b);
    assign w_ex_load = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex    <= C_BUBBLE;
            r_mem   <= C_BUBBLE;
            r_wb    <= C_BUBBLE;
            r_fwd_a <= REGFILE;
            r_fwd_b <= REGFILE;
        end else begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_ex_load) begin
                r_ex    <= w_id_info;
                r_fwd_a <= w_sel_a;
                r_fwd_b <= w_sel_b;
            end else begin
                r_ex    <= C_BUBBLE;
                r_fwd_a <= REGFILE;
                r_fwd_b <= REGFILE;
            end
        end
    end

    assign fwd_a_sel = r_fwd_a;
    assign fwd_b_sel = r_fwd_b;
    assign ex_valid  = r_ex.valid;

endmodule : fwd_ctrl

`default_nettype wire

// File: tb/tb_fwd_ctrl.sv
// ============================================================================
// Module      : tb_fwd_ctrl
// Description : Directed self-checking bench; one DUT writes through the
//               register file, the other enables WB-hold forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fwd_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rn = '0;
    logic [4:0] id_rm = '0;
    logic       id_use_rn = 1'b0;
    logic       id_use_rm = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_regwrite = 1'b0;
    logic       id_memread = 1'b0;
    logic       flush = 1'b0;

    logic       stall,     stall_h;
    logic [1:0] fwd_a_sel, fwd_a_h;
    logic [1:0] fwd_b_sel, fwd_b_h;
    logic       ex_valid,  ex_valid_h;

    logic       last_stall, last_stall_h;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    fwd_ctrl #(.REG_W(5), .ZERO_REG(31), .RF_WRITE_THROUGH(1)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .ex_valid(ex_valid)
    );

    fwd_ctrl #(.REG_W(5), .ZERO_REG(31), .RF_WRITE_THROUGH(0)) dut_h (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .stall(stall_h), .fwd_a_sel(fwd_a_h),
        .fwd_b_sel(fwd_b_h), .ex_valid(ex_valid_h)
    );

    // Present one ID-stage instruction, capture stall before the edge, then clock it
    task automatic issue(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic urn, input logic urm, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic fl);
        id_valid = v;  id_rn = rn;  id_rm = rm;  id_use_rn = urn;  id_use_rm = urm;
        id_rd = rd;    id_regwrite = rw;  id_memread = mr;  flush = fl;
        #1;
        last_stall   = stall;
        last_stall_h = stall_h;
        @(posedge clk);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        #1;
        checks++; if ({stall, fwd_a_sel, fwd_b_sel, ex_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b required 000000", {stall, fwd_a_sel, fwd_b_sel, ex_valid});
        end
        checks++; if ({stall_h, fwd_a_h, fwd_b_h, ex_valid_h} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs_h: got %b required 000000", {stall_h, fwd_a_h, fwd_b_h, ex_valid_h});
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ex_fwd;
        nops(3);
        issue(1, 5'd7, 5'd8, 1, 1, 5'd1, 1, 0, 0);       // ADD X1
        issue(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0);       // SUB X9, X1, X2
        checks++; if (last_stall !== 1'b0) begin
            errors++; $display("FAIL ex_fwd_stall: got %b required 0", last_stall);
        end
        checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL ex_fwd_sel: got a=%b b=%b required a=01 b=00", fwd_a_sel, fwd_b_sel);
        end
        checks++; if (ex_valid !== 1'b1) begin
            errors++; $display("FAIL ex_fwd_valid: got %b required 1", ex_valid);
        end
        // X9 in EX but the reader does not use rm
        issue(1, 5'd3, 5'd9, 1, 0, 5'd10, 1, 0, 0);
        checks++; if (fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL unused_src: got %b required 00", fwd_b_sel);
        end
    endtask

    task automatic test_mem_wb_fwd;
        nops(3);
        issue(1, 5'd7, 5'd8, 1, 1, 5'd2, 1, 0, 0);       // ADD X2
        nops(1);
        issue(1, 5'd6, 5'd2, 1, 1, 5'd11, 1, 0, 0);      // ORR rm=2
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b10 || fwd_b_h !== 2'b10) begin
            errors++; $display("FAIL mem_fwd: got a=%b b=%b bh=%b required 00 10 10", fwd_a_sel, fwd_b_sel, fwd_b_h);
        end
        nops(3);
        issue(1, 5'd7, 5'd8, 1, 1, 5'd2, 1, 0, 0);
        nops(2);
        issue(1, 5'd6, 5'd2, 1, 1, 5'd11, 1, 0, 0);
        checks++; if (fwd_b_h !== 2'b11) begin
            errors++; $display("FAIL wbhold_fwd: got %b required 11", fwd_b_h);
        end
        checks++; if (fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL writethrough_no_wbhold: got %b required 00", fwd_b_sel);
        end
    endtask

    task automatic test_priority;
        nops(3);
        issue(1, 5'd1, 5'd1, 0, 0, 5'd8, 1, 0, 0);       // ADD X8
        issue(1, 5'd1, 5'd1, 0, 0, 5'd8, 1, 0, 0);       // ADD X8 again
        issue(1, 5'd8, 5'd8, 1, 1, 5'd12, 1, 0, 0);
        checks++; if (fwd_a_sel !== 2'b01 || fwd_b_sel !== 2'b01) begin
            errors++; $display("FAIL youngest_priority: got a=%b b=%b required 01 01", fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_load_use;
        nops(3);
        issue(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0);       // LDUR X3
        issue(1, 5'd3, 5'd3, 1, 1, 5'd13, 1, 0, 0);      // ADD X13, X3, X3
        checks++; if (last_stall !== 1'b1 || last_stall_h !== 1'b1) begin
            errors++; $display("FAIL load_use_stall: got %b/%b required 1/1", last_stall, last_stall_h);
        end
        checks++; if (ex_valid !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL load_use_bubble: got v=%b a=%b b=%b required 0 00 00", ex_valid, fwd_a_sel, fwd_b_sel);
        end
        issue(1, 5'd3, 5'd3, 1, 1, 5'd13, 1, 0, 0);      // replay held instruction
        checks++; if (last_stall !== 1'b0) begin
            errors++; $display("FAIL load_use_one_stall: got %b required 0", last_stall);
        end
        checks++; if (ex_valid !== 1'b1 || fwd_a_sel !== 2'b10 || fwd_b_sel !== 2'b10) begin
            errors++; $display("FAIL load_use_fwd: got v=%b a=%b b=%b required 1 10 10", ex_valid, fwd_a_sel, fwd_b_sel);
        end
    endtask

    task automatic test_back_to_back;
        nops(3);
        issue(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1, 0);       // LDUR X3
        issue(1, 5'd0, 5'd0, 1, 0, 5'd3, 1, 1, 0);       // LDUR X3 (reads X0)
        checks++; if (last_stall !== 1'b0) begin
            errors++; $display("FAIL b2b_second_load_stall: got %b required 0", last_stall);
        end
        issue(1, 5'd3, 5'd0, 1, 0, 5'd14, 1, 0, 0);
        checks++; if (last_stall !== 1'b1) begin
            errors++; $display("FAIL b2b_stall: got %b required 1", last_stall);
        end
        issue(1, 5'd3, 5'd0, 1, 0, 5'd14, 1, 0, 0);
        checks++; if (last_stall !== 1'b0 || fwd_a_sel !== 2'b10 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_fwd: got stall=%b a=%b v=%b required 0 10 1", last_stall, fwd_a_sel, ex_valid);
        end
    endtask

    task automatic test_zero_reg;
        nops(3);
        issue(1, 5'd1, 5'd2, 1, 1, 5'd31, 1, 0, 0);      // write XZR
        issue(1, 5'd31, 5'd31, 1, 1, 5'd15, 1, 0, 0);
        checks++; if (last_stall !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL zero_reg_alu: got stall=%b a=%b b=%b required 0 00 00", last_stall, fwd_a_sel, fwd_b_sel);
        end
        nops(3);
        issue(1, 5'd1, 5'd0, 1, 0, 5'd31, 1, 1, 0);      // load into XZR
        issue(1, 5'd31, 5'd0, 1, 0, 5'd15, 1, 0, 0);
        checks++; if (last_stall !== 1'b0 || fwd_a_sel !== 2'b00) begin
            errors++; $display("FAIL zero_reg_load: got stall=%b a=%b required 0 00", last_stall, fwd_a_sel);
        end
    endtask

    task automatic test_flush;
        nops(3);
        issue(1, 5'd1, 5'd0, 1, 0, 5'd4, 1, 1, 0);       // LDUR X4
        issue(1, 5'd4, 5'd0, 1, 0, 5'd16, 1, 0, 1);      // ADD rn=4 flushed
        checks++; if (last_stall !== 1'b0) begin
            errors++; $display("FAIL flush_masks_stall: got %b required 0", last_stall);
        end
        checks++; if (ex_valid !== 1'b0 || fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00) begin
            errors++; $display("FAIL flush_bubble: got v=%b a=%b b=%b required 0 00 00", ex_valid, fwd_a_sel, fwd_b_sel);
        end
        // The load kept advancing: it is now in MEM
        issue(1, 5'd4, 5'd0, 1, 0, 5'd16, 1, 0, 0);
        checks++; if (last_stall !== 1'b0 || fwd_a_sel !== 2'b10) begin
            errors++; $display("FAIL flush_older_advance: got stall=%b a=%b required 0 10", last_stall, fwd_a_sel);
        end
    endtask

    task automatic test_reset_mid;
        nops(3);
        issue(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);       // ADD X5
        id_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({stall, fwd_a_sel, fwd_b_sel, ex_valid} !== 6'b0 || ex_valid_h !== 1'b0) begin
            errors++; $display("FAIL reset_async: got %b/%b required 000000/0", {stall, fwd_a_sel, fwd_b_sel, ex_valid}, ex_valid_h);
        end
        @(posedge clk); #2;
        reset_n = 1'b1;
        #1;
        issue(1, 5'd5, 5'd5, 1, 1, 5'd17, 1, 0, 0);
        checks++; if (fwd_a_sel !== 2'b00 || fwd_b_sel !== 2'b00 || fwd_a_h !== 2'b00 || fwd_b_h !== 2'b00) begin
            errors++; $display("FAIL post_reset_reader: got %b%b %b%b required 0000 0000", fwd_a_sel, fwd_b_sel, fwd_a_h, fwd_b_h);
        end
        checks++; if (ex_valid !== 1'b1) begin
            errors++; $display("FAIL post_reset_valid: got %b required 1", ex_valid);
        end
    endtask

    initial begin
        test_reset();
        test_ex_fwd();
        test_mem_wb_fwd();
        test_priority();
        test_load_use();
        test_back_to_back();
        test_zero_reg();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fwd_ctrl

`default_nettype wire
